// File: rtl/arbiter_rr4.sv
// arbiter_rr4 -- four-input round-robin arbiter in front of the destination demux.
//
// Drains four show-ahead input FIFOs, one word per cycle, onto a single bus.
// Word bits [DEST_LSB+1:DEST_LSB] name the destination. An input is skipped
// while its destination is paused, so a blocked destination never holds up
// traffic that is bound elsewhere.
//
// Optional feature: define ARB_GRANT_CNT_EN to add per-input saturating
// grant counters (gcnt0..gcnt3) and their synchronous clear (cnt_clr).
//
// Ports
//   clk        in   1        single clock, posedge
//   reset      in   1        asynchronous, active-high
//   in0..in3   in   DATA_W   head word of input FIFO i (valid when !empty[i])
//   empty      in   4        input FIFO i is empty
//   pause      in   4        destination d cannot accept a word
//   pop        out  4        one-hot/zero pop to the input FIFOs (combinational)
//   data_out   out  DATA_W   registered granted word
//   valid_out  out  1        data_out carries a new word this cycle
//   state      out  2        00 IDLE, 01 ACTIVE, 10 STALL
//   idle       out  1        state is IDLE and every input is empty
//   cnt_clr    in   1        (ARB_GRANT_CNT_EN) synchronous clear of the counters
//   gcnt0..3   out  CNT_W    (ARB_GRANT_CNT_EN) saturating grant counts per input
module arbiter_rr4 #(
  parameter int DATA_W   = 12,
  parameter int DEST_LSB = 8,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [3:0]        empty,
  input  logic [3:0]        pause,
  output logic [3:0]        pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        state,
`ifdef ARB_GRANT_CNT_EN
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  gcnt0,
  output logic [CNT_W-1:0]  gcnt1,
  output logic [CNT_W-1:0]  gcnt2,
  output logic [CNT_W-1:0]  gcnt3,
`endif
  output logic              idle
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    STALL  = 2'b10
  } state_e;

  function automatic logic [1:0] dest_of(input logic [DATA_W-1:0] w);
    return w[DEST_LSB+1:DEST_LSB];
  endfunction

  logic [DATA_W-1:0] in_w [4];
  logic [3:0]        elig;
  logic [3:0]        gnt_oh;
  logic [1:0]        gnt_idx;
  logic              gnt_any;

  logic [DATA_W-1:0] data_out_q;
  logic              valid_out_q;
  logic [1:0]        ptr_q, ptr_d;
  state_e            state_q, state_d;

  assign in_w[0] = in0;
  assign in_w[1] = in1;
  assign in_w[2] = in2;
  assign in_w[3] = in3;

  // Pause is looked up through the head word's own destination field, so a
  // pause change affects eligibility in the very same cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 4; i++) begin
      elig[i] = !empty[i] && !pause[dest_of(in_w[i])];
    end
  end

  // First eligible input scanning ptr, ptr+1, ptr+2, ptr+3; the 2-bit index
  // wraps naturally.
  always_comb begin
    logic [1:0] idx;
    idx     = ptr_q;
    gnt_idx = ptr_q;
    gnt_any = 1'b0;
    gnt_oh  = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_any) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  // Pop is killed during reset so no word leaves a FIFO without being captured.
  assign pop   = reset ? 4'b0000 : gnt_oh;
  assign ptr_d = gnt_any ? (gnt_idx + 2'd1) : ptr_q;

  always_comb begin
    state_d = state_q;
    if (&empty) begin
      state_d = IDLE;
    end else if (|elig) begin
      state_d = ACTIVE;
    end else begin
      state_d = STALL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register: data holds when nothing is granted, only valid drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      ptr_q       <= 2'd0;
    end else begin
      valid_out_q <= gnt_any;
      ptr_q       <= ptr_d;
      if (gnt_any) begin
        data_out_q <= in_w[gnt_idx];
      end
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign state     = state_q;
  assign idle      = (state_q == IDLE) && (&empty);

`ifdef ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] gcnt_q [4];

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) gcnt_q[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < 4; i++) gcnt_q[i] <= '0;
    end else if (gnt_any && (gcnt_q[gnt_idx] != {CNT_W{1'b1}})) begin
      gcnt_q[gnt_idx] <= gcnt_q[gnt_idx] + CNT_W'(1);
    end
  end

  assign gcnt0 = gcnt_q[0];
  assign gcnt1 = gcnt_q[1];
  assign gcnt2 = gcnt_q[2];
  assign gcnt3 = gcnt_q[3];
`endif

endmodule

// File: tb/tb_arbiter_rr4.sv
module tb_arbiter_rr4;

  logic        clk;
  logic        reset;
  logic [11:0] in0, in1, in2, in3;
  logic [3:0]  empty;
  logic [3:0]  pause;
  logic [3:0]  pop;
  logic [11:0] data_out;
  logic        valid_out;
  logic [1:0]  state;
  logic        idle;
`ifdef ARB_GRANT_CNT_EN
  logic        cnt_clr;
  logic [7:0]  gcnt0, gcnt1, gcnt2, gcnt3;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  arbiter_rr4 #(.DATA_W(12), .DEST_LSB(8), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .empty     (empty),
    .pause     (pause),
    .pop       (pop),
    .data_out  (data_out),
    .valid_out (valid_out),
    .state     (state),
`ifdef ARB_GRANT_CNT_EN
    .cnt_clr   (cnt_clr),
    .gcnt0     (gcnt0),
    .gcnt1     (gcnt1),
    .gcnt2     (gcnt2),
    .gcnt3     (gcnt3),
`endif
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [11:0] v [4];

  initial begin
    reset = 1'b1;
    empty = 4'b0000;
    pause = 4'b0000;
    v[0] = 12'h011; v[1] = 12'h022; v[2] = 12'h033; v[3] = 12'h044;
    in0 = v[0]; in1 = v[1]; in2 = v[2]; in3 = v[3];
`ifdef ARB_GRANT_CNT_EN
    cnt_clr = 1'b0;
`endif

    // T1: reset held with all inputs non-empty
    repeat (3) @(posedge clk);
    #1;
    check("T1 pop", pop, 4'b0000);
    check("T1 valid", valid_out, 1'b0);
    check("T1 data", data_out, 12'h000);
    check("T1 state", state, 2'b00);
    check("T1 idle", idle, 1'b0);
    reset = 1'b0;

    // T2: all eligible, strict rotation 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      #1;
      check("T2 pop", pop, 32'(4'b0001 << (i % 4)));
      tick();
      check("T2 data", data_out, v[i % 4]);
      check("T2 valid", valid_out, 1'b1);
      check("T2 state", state, 2'b01);
    end

    // T3: only in2 non-empty (ptr=1 then ptr=3)
    empty = 4'b1011; in2 = 12'h2A5;
    #1 check("T3 pop p1", pop, 4'b0100);
    tick();
    check("T3 data p1", data_out, 12'h2A5);
    check("T3 pop p3", pop, 4'b0100);
    tick();
    check("T3 data p3", data_out, 12'h2A5);
    check("T3 valid", valid_out, 1'b1);

    // T4: dest 1 paused -> in1 granted, in0 held; release -> in0 same cycle
    in0 = 12'h100; in1 = 12'h200; empty = 4'b1100; pause = 4'b0010;
    #1 check("T4 pop paused", pop, 4'b0010);
    tick();
    check("T4 data in1", data_out, 12'h200);
    pause = 4'b0000; empty = 4'b1110;
    #1 check("T4 pop release", pop, 4'b0001);
    tick();
    check("T4 data in0", data_out, 12'h100);
    check("T4 valid", valid_out, 1'b1);

    // All empty -> IDLE, data holds
    empty = 4'b1111;
    #1 check("IDLE pop", pop, 4'b0000);
    tick();
    check("IDLE valid", valid_out, 1'b0);
    check("IDLE state", state, 2'b00);
    check("IDLE idle", idle, 1'b1);
    check("IDLE data hold", data_out, 12'h100);

    // Pause arrives with the word: no grant
    empty = 4'b1110; pause = 4'b0010;
    #1 check("PNE pop", pop, 4'b0000);
    tick();
    check("PNE valid", valid_out, 1'b0);
    check("PNE state", state, 2'b10);
    check("PNE idle", idle, 1'b0);

    // T5: all non-empty, all paused -> STALL; clear -> ACTIVE (ptr=1)
    in2 = 12'h2A5; in3 = 12'h344; empty = 4'b0000; pause = 4'b1111;
    #1 check("T5 pop", pop, 4'b0000);
    tick();
    check("T5 state stall", state, 2'b10);
    check("T5 valid", valid_out, 1'b0);
    pause = 4'b0000;
    #1 check("T5 pop clr", pop, 4'b0010);
    tick();
    check("T5 state act", state, 2'b01);
    check("T5 data", data_out, 12'h200);

    // FIFO goes empty as it is popped (ptr=2, only in3)
    empty = 4'b0111;
    #1 check("EOP pop", pop, 4'b1000);
    tick();
    check("EOP data", data_out, 12'h344);
    empty = 4'b1111;
    #1 check("EOP no regrant", pop, 4'b0000);
    tick();
    check("EOP valid", valid_out, 1'b0);
    check("EOP state", state, 2'b00);

    // Reset mid-transfer (ptr=0)
    empty = 4'b0000;
    #1 check("RST pop pre", pop, 4'b0001);
    tick();
    check("RST valid pre", valid_out, 1'b1);
    reset = 1'b1;
    #1;
    check("RST valid drop", valid_out, 1'b0);
    check("RST data", data_out, 12'h000);
    check("RST pop", pop, 4'b0000);
    check("RST state", state, 2'b00);
    tick();
    reset = 1'b0;
    empty = 4'b1110;
    #1 check("RST ptr", pop, 4'b0001);

`ifdef ARB_GRANT_CNT_EN
    // T6: saturation then clear during a grant
    repeat (300) tick();
    check("T6 sat", gcnt0, 8'hFF);
    check("T6 gcnt1", gcnt1, 8'h00);
    cnt_clr = 1'b1;
    tick();
    check("T6 clr", gcnt0, 8'h00);
    cnt_clr = 1'b0;
    tick();
    check("T6 inc", gcnt0, 8'h01);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
